lvdc_parity_monitor: RTL

Syllable parity checker and retry sequencer that consumes the buffer register contents after each memory read. On every check strobe it tests the 13 syllable bits plus the stored parity bit for odd parity. On a parity error it first requests a re-read from the same memory module. If that re-read also fails, it switches the duplex memory selection and requests one more read. If that fails too, or a retry never completes, it declares a sticky memory fault.

---
 rtl/lvdc_parity_monitor_if.sv | 28 ++
 rtl/lvdc_parity_monitor.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/lvdc_parity_monitor_if.sv
// Buffer-register check bus between the memory read path and the parity monitor.
// The producer drives the syllable and strobes; the monitor returns status and retry requests.
interface lvdc_parity_monitor_if #(
  parameter int CNTW = 8
);
  logic            CHK;
  logic [13:1]     BRx;
  logic            BRxP;
  logic            SYL;
  logic            CLRERR;
  logic            OK;
  logic            PERR;
  logic            RETRY;
  logic            DUPSEL;
  logic            FAULT;
  logic            ERRSYL;
  logic [CNTW-1:0] ERRCNT;

  modport master (
    output CHK, BRx, BRxP, SYL, CLRERR,
    input  OK, PERR, RETRY, DUPSEL, FAULT, ERRSYL, ERRCNT
  );

  modport slave (
    input  CHK, BRx, BRxP, SYL, CLRERR,
    output OK, PERR, RETRY, DUPSEL, FAULT, ERRSYL, ERRCNT
  );
endinterface

// File: rtl/lvdc_parity_monitor.sv
// Odd-parity syllable checker with re-read, duplex-switch and sticky-fault escalation.
// All status outputs are registered one cycle after the CHK strobe is sampled.
module lvdc_parity_monitor #(
  parameter int TIMEOUT = 64,
  parameter int CNTW    = 8
) (
  input  logic                clk,
  input  logic                rst,
  lvdc_parity_monitor_if.slave bus
);
  localparam int              TMOW    = $clog2(TIMEOUT + 1);
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_RETRY_WAIT,
    S_SWITCH_WAIT,
    S_FAULT
  } state_t;

  state_t          r_state;
  logic            r_ok;
  logic            r_retry;
  logic            r_perr;
  logic            r_dupsel;
  logic            r_fault;
  logic            r_errsyl;
  logic [CNTW-1:0] r_errcnt;
  logic [TMOW-1:0] r_tmo;

  state_t          w_state_next;
  logic            w_ok_next;
  logic            w_retry_next;
  logic            w_perr_next;
  logic            w_dupsel_next;
  logic            w_fault_next;
  logic            w_errsyl_next;
  logic [CNTW-1:0] w_errcnt_next;
  logic [TMOW-1:0] w_tmo_next;
  logic            w_good;
  logic            w_tmo_hit;
  logic [CNTW-1:0] w_errcnt_inc;

  // Odd number of ones across syllable plus stored parity means good.
  assign w_good       = ^{bus.BRx, bus.BRxP};
  // r_tmo holds the count of completed idle wait cycles, so this is the TIMEOUT-th one.
  assign w_tmo_hit    = (r_tmo == TMOW'(TIMEOUT - 1));
  assign w_errcnt_inc = (r_errcnt == CNT_MAX) ? r_errcnt : r_errcnt + CNTW'(1);

  always_comb begin
    w_state_next  = r_state;
    w_ok_next     = 1'b0;
    w_retry_next  = 1'b0;
    w_perr_next   = r_perr;
    w_dupsel_next = r_dupsel;
    w_fault_next  = r_fault;
    w_errsyl_next = r_errsyl;
    w_errcnt_next = r_errcnt;
    w_tmo_next    = r_tmo;

    if (bus.CLRERR) begin
      w_state_next  = S_IDLE;
      w_perr_next   = 1'b0;
      w_fault_next  = 1'b0;
      w_errsyl_next = 1'b0;
      w_errcnt_next = '0;
      w_tmo_next    = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.CHK) begin
            if (w_good) begin
              w_ok_next = 1'b1;
            end else begin
              w_perr_next   = 1'b1;
              w_errsyl_next = bus.SYL;
              w_errcnt_next = w_errcnt_inc;
              w_retry_next  = 1'b1;
              w_tmo_next    = '0;
              w_state_next  = S_RETRY_WAIT;
            end
          end
        end
        S_RETRY_WAIT: begin
          if (bus.CHK) begin
            if (w_good) begin
              w_ok_next    = 1'b1;
              w_state_next = S_IDLE;
            end else begin
              w_errcnt_next = w_errcnt_inc;
              w_dupsel_next = ~r_dupsel;
              w_retry_next  = 1'b1;
              w_tmo_next    = '0;
              w_state_next  = S_SWITCH_WAIT;
            end
          end else if (w_tmo_hit) begin
            w_fault_next = 1'b1;
            w_state_next = S_FAULT;
          end else begin
            w_tmo_next = r_tmo + TMOW'(1);
          end
        end
        S_SWITCH_WAIT: begin
          if (bus.CHK) begin
            if (w_good) begin
              w_ok_next    = 1'b1;
              w_state_next = S_IDLE;
            end else begin
              w_errcnt_next = w_errcnt_inc;
              w_fault_next  = 1'b1;
              w_state_next  = S_FAULT;
            end
          end else if (w_tmo_hit) begin
            w_fault_next = 1'b1;
            w_state_next = S_FAULT;
          end else begin
            w_tmo_next = r_tmo + TMOW'(1);
          end
        end
        default: begin
          w_state_next = S_FAULT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ok     <= 1'b0;
      r_retry  <= 1'b0;
      r_perr   <= 1'b0;
      r_dupsel <= 1'b0;
      r_fault  <= 1'b0;
      r_errsyl <= 1'b0;
      r_errcnt <= '0;
      r_tmo    <= '0;
    end else begin
      r_state  <= w_state_next;
      r_ok     <= w_ok_next;
      r_retry  <= w_retry_next;
      r_perr   <= w_perr_next;
      r_dupsel <= w_dupsel_next;
      r_fault  <= w_fault_next;
      r_errsyl <= w_errsyl_next;
      r_errcnt <= w_errcnt_next;
      r_tmo    <= w_tmo_next;
    end
  end

  assign bus.OK     = r_ok;
  assign bus.RETRY  = r_retry;
  assign bus.PERR   = r_perr;
  assign bus.DUPSEL = r_dupsel;
  assign bus.FAULT  = r_fault;
  assign bus.ERRSYL = r_errsyl;
  assign bus.ERRCNT = r_errcnt;
endmodule
